// File: rtl/pcPkg.sv
// pcPkg: PC/address-unit select encodings and the memory sequencer state type.
// MEM_SEQ_TIMEOUT_EN adds the ERR state used by the bus timeout.
`default_nettype none

package pcPkg;

  typedef enum logic [1:0] {
    PC_OLD = 2'd0,
    PC_P4  = 2'd1,
    PC_M4  = 2'd2,
    PC_ALU = 2'd3
  } pc_sel;

  typedef enum logic {
    MEM_PC  = 1'b0,
    MEM_ALU = 1'b1
  } mem_sel;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
`ifdef MEM_SEQ_TIMEOUT_EN
    ,
    ERR    = 3'd7
`endif
  } seq_state;

endpackage

`default_nettype wire

// File: rtl/mem_seq_timer.sv
// mem_seq_timer: wait-cycle counter for one memory request; expired marks the
// last cycle the sequencer may still wait for an acknowledge.
`default_nettype none

module mem_seq_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the PC/address selects
// and the shared memory handshake. MEM_SEQ_TIMEOUT_EN enables the bus timeout.
`default_nettype none

module mem_seq_ctrl
  import pcPkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       take_pc,
  input  logic       replay,
  input  logic       mem_ack,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       rf_we,
  output logic       retired,
  output logic       halted,
  output logic       bus_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  seq_state state, nxt;
  seq_state after_retire;
  logic     st_flag;
  logic     expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Decoder inputs are only valid in EXEC, so the access type is held for MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      st_flag <= 1'b0;
    else if (state == EXEC && nxt == MEM)
      st_flag <= is_store;
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  logic tmr_clr, tmr_en;
  assign tmr_clr = (nxt != state) && (nxt == FETCH || nxt == MEM);
  assign tmr_en  = mem_req && !mem_ack;

  mem_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign after_retire = halt ? HALT : FETCH;

  always_comb begin
    nxt     = state;
    pc_sel  = PC_OLD;
    mem_sel = MEM_PC;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    rf_we   = 1'b0;
    retired = 1'b0;
    halted  = 1'b0;
    bus_err = 1'b0;
    case (state)
      IDLE: nxt = after_retire;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_sel  = PC_P4;
          nxt     = DECODE;
        end
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (expired) nxt = ERR;
`endif
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        if (replay) begin
          pc_sel = PC_M4;
          nxt    = after_retire;
        end else if (take_pc) begin
          pc_sel  = PC_ALU;
          retired = 1'b1;
          nxt     = after_retire;
        end else if (is_load || is_store) begin
          nxt = MEM;
        end else begin
          rf_we   = 1'b1;
          retired = 1'b1;
          nxt     = after_retire;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_sel = MEM_ALU;
        mem_we  = st_flag;
        if (mem_ack) begin
          retired = st_flag;
          nxt     = st_flag ? after_retire : WB;
        end
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (expired) nxt = ERR;
`endif
      end
      WB: begin
        rf_we   = 1'b1;
        retired = 1'b1;
        nxt     = after_retire;
      end
      HALT: begin
        halted = 1'b1;
        if (!halt) nxt = FETCH;
      end
`ifdef MEM_SEQ_TIMEOUT_EN
      ERR: begin
        halted  = 1'b1;
        bus_err = 1'b1;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  logic unused_expired;
  assign unused_expired = expired;

endmodule

`default_nettype wire
